// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed 7-segment scanner.
// Each digit slot lasts SCAN_DIV cycles. The first BLANK_CYC cycles of a slot
// are a guard period with every digit turned off. The four BCD inputs are
// captured together once per frame, so a digit cannot change partway through
// a frame. The an/seg outputs are registered and lag the scan state by one clock.
// Optional build macro: LEADING_ZERO_BLANK_EN turns off the segments of zero
// digits (thousands, hundreds, tens) when every digit above them is also zero.
module seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] g,
  input  logic [3:0] s,
  input  logic [3:0] b,
  input  logic [3:0] q,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    idx_reg, idx_next;
  logic [0:0]    state_reg, state_next;
  logic          start_reg;
  logic          latch;
  logic [3:0]    digit_in [4];
  logic [3:0]    frame_reg [4];
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;
  logic          frame_start_reg;

  assign digit_in[0] = g;
  assign digit_in[1] = s;
  assign digit_in[2] = b;
  assign digit_in[3] = q;

  // Capture at the frame boundary (last cycle of the thousands slot) or on the first clock after reset.
  assign latch = start_reg || (idx_reg == 2'd3 && cnt_reg == CNT_MAX);

  // Next slot counter, digit index and FSM state; the state always matches the counter it is stored with.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    idx_next = idx_reg;
    if (cnt_reg == CNT_MAX) begin
      cnt_next = '0;
      idx_next = idx_reg + 1'b1;
    end
    state_next = (cnt_next < BLANK_END) ? ST_BLANK : ST_SHOW;
  end

  // Scan position and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      state_reg <= ST_BLANK;
      start_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      state_reg <= state_next;
      start_reg <= 1'b0;
    end
  end

  // One frame register per digit, all loaded together on a latch event.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_frame
      always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_reg[gi] <= '0;
        else if (latch) frame_reg[gi] <= digit_in[gi];
      end
    end
  endgenerate

  assign cur_digit = frame_reg[idx_reg];

`ifdef LEADING_ZERO_BLANK_EN
  // A leading zero is blanked only when every higher digit is zero too; the ones digit is always shown.
  always_comb begin
    cur_blank = 1'b0;
    case (idx_reg)
      2'd3: cur_blank = (frame_reg[3] == 4'd0);
      2'd2: cur_blank = (frame_reg[3] == 4'd0) && (frame_reg[2] == 4'd0);
      2'd1: cur_blank = (frame_reg[3] == 4'd0) && (frame_reg[2] == 4'd0) && (frame_reg[1] == 4'd0);
      default: cur_blank = 1'b0;
    endcase
  end
`else
  assign cur_blank = 1'b0;
`endif

  // BCD to active-low {g,f,e,d,c,b,a}; values that are not BCD digits show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // Output values for the current scan state: all off in the guard period, one digit on otherwise.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = 7'h7F;
    if (state_reg == ST_SHOW) begin
      an_next  = ~(4'b0001 << idx_reg);
      seg_next = cur_blank ? 7'h7F : decode(cur_digit);
    end
  end

  // Registered outputs; reset clears them at once so the display goes dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg          <= 4'b1111;
      seg_reg         <= 7'h7F;
      frame_start_reg <= 1'b0;
    end else begin
      an_reg          <= an_next;
      seg_reg         <= seg_next;
      frame_start_reg <= latch;
    end
  end

  assign an          = an_reg;
  assign seg         = seg_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan with SCAN_DIV=8 and BLANK_CYC=2.
// At every clock the expected an/seg/frame_start values go into a queue.
// After the clock edge they are taken out and compared on the falling edge.
module tb_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] g = 4'd4, s = 4'd3, b = 4'd2, q = 4'd1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_start;

  exp_t       sb[$];
  int         total = 0;
  int         passed = 0;
  int         k = 0;
  logic [3:0] fr [4];
  logic [6:0] dec_tab [16];

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .g(g), .s(s), .b(b), .q(q),
    .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, expv);
    end
  endtask

  // Reference: the output after edge k shows scan position k-1, using frames latched before edge k.
  function automatic exp_t predict(input int kk);
    exp_t e;
    int   cp, ix;
    logic blank;
    cp = kk - 1;
    e.fs = (kk == 1) || (kk % FRAME == 0);
    if (cp % SD < BC) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
    end else begin
      ix    = (cp / SD) % 4;
      e.an  = ~(4'b0001 << ix);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (ix > 0) begin
        blank = 1'b1;
        for (int j = ix; j < 4; j++) if (fr[j] != 4'd0) blank = 1'b0;
      end
`endif
      e.seg = blank ? 7'h7F : dec_tab[fr[ix]];
    end
    return e;
  endfunction

  task automatic step();
    exp_t e;
    if (rst) begin
      k = 0;
      for (int i = 0; i < 4; i++) fr[i] = 4'd0;
      e = '{an: 4'hF, seg: 7'h7F, fs: 1'b0};
    end else begin
      k++;
      e = predict(k);
      if (e.fs) begin
        fr[0] = g; fr[1] = s; fr[2] = b; fr[3] = q;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("an", 16'(an), 16'(e.an));
    check("seg", 16'(seg), 16'(e.seg));
    check("frame_start", 16'(frame_start), 16'(e.fs));
    $display("k=%0d rst=%0b an=%b seg=%h fs=%0b", k, rst, an, seg, frame_start);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int phase);
    int guard = 0;
    while (k % FRAME != phase && guard < 200) begin
      step();
      guard++;
    end
    check("run_to_bound", 16'(k % FRAME), 16'(phase));
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    for (int i = 0; i < 4; i++) fr[i] = 4'd0;

    // Reset held for 5 cycles with digits 1,2,3,4 on the inputs.
    @(negedge clk);
    run(5);
    rst = 1'b0;

    // Steady scanning for two frames.
    run(2 * FRAME);

    // Change the ones digit during the tens slot; it must not show before the next frame.
    run_to(10);
    g = 4'd9;
    run(2 * FRAME);

    // A non-BCD ones digit shows a dash.
    g = 4'hC;
    run(2 * FRAME);

    // Leading zeros.
    q = 4'd0; b = 4'd0; s = 4'd0; g = 4'd7;
    run(2 * FRAME);
    b = 4'd5;
    run(2 * FRAME);

    // Reset in the middle of the hundreds slot (cnt=4, idx=2) must blank the outputs before the next edge.
    q = 4'd1; b = 4'd2; s = 4'd3; g = 4'd4;
    run(FRAME);
    run_to(20);
    #1 rst = 1'b1;
    #1;
    check("async_an", 16'(an), 16'(4'hF));
    check("async_seg", 16'(seg), 16'(7'h7F));
    check("async_fs", 16'(frame_start), 16'(1'b0));
    @(negedge clk);
    run(3);
    rst = 1'b0;
    run(FRAME + 10);

    check("queue_empty", 16'(sb.size()), 16'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
